// File: rtl/timer_pkg.sv
// Shared definitions for the timer scheduler: counter state codes, command
// opcodes, mode encoding, the controller FSM state type, and a helper that maps
// an FSM state onto the code presented to the interval counter.
package timer_pkg;

  // State codes presented on ctr_state.
  localparam logic [7:0] CtrReset = 8'd0;
  localparam logic [7:0] CtrRun   = 8'd1;
  localparam logic [7:0] CtrHalt  = 8'd2;

  // Command opcodes.
  localparam int unsigned OpNop         = 0;
  localparam int unsigned OpStart       = 1;
  localparam int unsigned OpStop        = 2;
  localparam int unsigned OpClear       = 3;
  localparam int unsigned OpSetInterval = 4;
  localparam int unsigned OpSetTarget   = 5;
  localparam int unsigned OpSetMode     = 6;
  localparam int unsigned OpRsvd        = 7;

  // Mode register encoding (cmd_data[0] of SET_MODE).
  localparam logic ModeOneShot  = 1'b0;
  localparam logic ModePeriodic = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StHalt,
    StReload
  } timer_state_e;

  // RELOAD holds the counter in RESET for its single cycle, same as IDLE.
  function automatic logic [7:0] ctr_code(timer_state_e st);
    logic [7:0] code;
    case (st)
      StRun:   code = CtrRun;
      StHalt:  code = CtrHalt;
      default: code = CtrReset;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/timer_match.sv
// Match detector: holds the match target and an edge-detect history flop, and
// raises match_o for one cycle each time the running count arrives at the target.
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   run_i            controller is in RUN this cycle
//   target_we_i      load target_wdata_i into the target register
//   target_wdata_i   new target value
//   ctr_value_i      current count from the interval counter
//   match_o          combinational match pulse for this cycle
module timer_match (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        run_i,
  input  logic        target_we_i,
  input  logic [31:0] target_wdata_i,
  input  logic [31:0] ctr_value_i,
  output logic        match_o
);

  logic [31:0] target_q, target_d;
  logic        seen_q, seen_d;
  logic        equal;

  always_comb begin
    target_d = target_we_i ? target_wdata_i : target_q;
    equal    = (ctr_value_i == target_q);
    // History only records RUN cycles, so any cycle outside RUN clears it and the
    // first RUN cycle after entry sees a fresh edge.
    seen_d   = run_i && equal;
    // A zero target disables matching entirely.
    match_o  = run_i && (target_q != '0) && equal && !seen_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      target_q <= '0;
      seen_q   <= 1'b0;
    end else begin
      target_q <= target_d;
      seen_q   <= seen_d;
    end
  end

endmodule

// File: rtl/timer_sched.sv
// Timer scheduler: command-driven controller for an external interval counter.
// Decodes START/STOP/CLEAR/SET_* commands, sequences IDLE/RUN/HALT/RELOAD, and
// counts target matches with a sticky interrupt. All outputs are registered.
//   clk, resetn              clock, asynchronous active-low reset
//   cmd_valid/ready/op/data  command handshake; cmd_err pulses on a rejected command
//   ctr_state, ctr_interval  control to the counter; ctr_value is its count
//   irq, irq_ack             sticky match interrupt and its clear
//   match_cnt                matches since last CLEAR (wrapping)
//   busy                     high in RUN or RELOAD
module timer_sched
  import timer_pkg::*;
#(
  parameter int unsigned CMD_W  = 3,
  parameter int unsigned MCNT_W = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CMD_W-1:0]  cmd_op,
  input  logic [31:0]       cmd_data,
  output logic              cmd_err,
  output logic [7:0]        ctr_state,
  output logic [31:0]       ctr_interval,
  input  logic [31:0]       ctr_value,
  output logic              irq,
  input  logic              irq_ack,
  output logic [MCNT_W-1:0] match_cnt,
  output logic              busy
);

  timer_state_e      state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              cmd_err_q, cmd_err_d;
  logic [7:0]        ctr_state_q, ctr_state_d;
  logic [31:0]       interval_q, interval_d;
  logic              mode_q, mode_d;
  logic              irq_q, irq_d;
  logic [MCNT_W-1:0] match_cnt_q, match_cnt_d;
  logic              busy_q, busy_d;

  logic cmd_acc;
  logic cfg_ok;
  logic target_we;
  logic match;

  timer_match u_match (
    .clk_i          (clk),
    .rst_ni         (resetn),
    .run_i          (state_q == StRun),
    .target_we_i    (target_we),
    .target_wdata_i (cmd_data),
    .ctr_value_i    (ctr_value),
    .match_o        (match)
  );

  always_comb begin
    state_d     = state_q;
    irq_d       = irq_q;
    match_cnt_d = match_cnt_q;
    interval_d  = interval_q;
    mode_d      = mode_q;
    cmd_err_d   = 1'b0;
    target_we   = 1'b0;
    cfg_ok      = (state_q == StIdle) || (state_q == StHalt);
    cmd_acc     = cmd_valid && cmd_ready_q;

    if (irq_ack) begin
      irq_d = 1'b0;
    end
    // A match outranks a simultaneous ack so no event is lost.
    if (match) begin
      irq_d       = 1'b1;
      match_cnt_d = match_cnt_q + MCNT_W'(1);
      state_d     = (mode_q == ModePeriodic) ? StReload : StHalt;
    end
    if (state_q == StReload) begin
      state_d = StRun;
    end

    // Commands are applied after the match so STOP/CLEAR win the transition.
    if (cmd_acc) begin
      case (cmd_op)
        CMD_W'(OpNop): ;
        CMD_W'(OpStart): begin
          if (cfg_ok) state_d = StRun;
        end
        CMD_W'(OpStop): begin
          if (state_q == StRun) state_d = StHalt;
        end
        CMD_W'(OpClear): begin
          state_d     = StIdle;
          irq_d       = 1'b0;
          match_cnt_d = '0;
        end
        CMD_W'(OpSetInterval): begin
          if (cfg_ok) interval_d = cmd_data;
          else        cmd_err_d  = 1'b1;
        end
        CMD_W'(OpSetTarget): begin
          if (cfg_ok) target_we = 1'b1;
          else        cmd_err_d = 1'b1;
        end
        CMD_W'(OpSetMode): begin
          if (cfg_ok) mode_d    = cmd_data[0];
          else        cmd_err_d = 1'b1;
        end
        CMD_W'(OpRsvd): cmd_err_d = 1'b1;
        default:        cmd_err_d = 1'b1;
      endcase
    end

    // Outputs are computed from the next state so they register alongside it.
    ctr_state_d = ctr_code(state_d);
    busy_d      = (state_d == StRun) || (state_d == StReload);
    cmd_ready_d = (state_d != StReload);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      cmd_ready_q <= 1'b1;
      cmd_err_q   <= 1'b0;
      ctr_state_q <= CtrReset;
      interval_q  <= '0;
      mode_q      <= ModeOneShot;
      irq_q       <= 1'b0;
      match_cnt_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      cmd_err_q   <= cmd_err_d;
      ctr_state_q <= ctr_state_d;
      interval_q  <= interval_d;
      mode_q      <= mode_d;
      irq_q       <= irq_d;
      match_cnt_q <= match_cnt_d;
      busy_q      <= busy_d;
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign cmd_err      = cmd_err_q;
  assign ctr_state    = ctr_state_q;
  assign ctr_interval = interval_q;
  assign irq          = irq_q;
  assign match_cnt    = match_cnt_q;
  assign busy         = busy_q;

endmodule

// File: doc/timer_sched.md
TIMER_SCHED -- requirements
Module: timer_sched

Interface
REQ-001 Parameter CMD_W, default 3, width of the command opcode.
REQ-002 Parameter MCNT_W, default 16, width of the match counter.
REQ-003 clk  input  1  sole clock; all logic on posedge clk.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 cmd_valid  input  1  command present.
REQ-006 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
REQ-007 cmd_op  input  CMD_W  opcode: 0 NOP, 1 START, 2 STOP, 3 CLEAR, 4 SET_INTERVAL, 5 SET_TARGET, 6 SET_MODE, 7 reserved.
REQ-008 cmd_data  input  32  operand for SET_* opcodes; SET_MODE uses bit 0 (0 one-shot, 1 periodic).
REQ-009 cmd_err  output  1  one-cycle pulse when an accepted command is rejected.
REQ-010 ctr_state  output  8  state code to the interval counter: 8'd0 RESET, 8'd1 RUN, 8'd2 HALT.
REQ-011 ctr_interval  output  32  prescale interval to the counter.
REQ-012 ctr_value  input  32  counter's current count.
REQ-013 irq  output  1  sticky match interrupt.
REQ-014 irq_ack  input  1  clears irq.
REQ-015 match_cnt  output  MCNT_W  number of matches since last CLEAR.
REQ-016 busy  output  1  high in RUN or RELOAD.

Function
REQ-017 FSM states: IDLE (ctr_state=RESET), RUN (RUN), HALT (HALT), RELOAD (RESET); all outputs registered.
REQ-018 IDLE: START -> RUN; STOP ignored, no error.
REQ-019 RUN: STOP -> HALT; CLEAR -> IDLE; START ignored.
REQ-020 HALT: START -> RUN (count resumes, not reset); CLEAR -> IDLE.
REQ-021 RELOAD lasts exactly one cycle, then RUN; cmd_ready=0 in RELOAD only.
REQ-022 Accepted SET_INTERVAL, SET_TARGET, SET_MODE update registers next cycle in IDLE or HALT; in RUN they are ignored and cmd_err pulses.
REQ-023 Accepted opcode 7 pulses cmd_err, no other effect.
REQ-024 CLEAR also zeroes match_cnt and irq; interval, target, mode retained.
REQ-025 Match event: in RUN, target!=0, ctr_value==target, and prior cycle's ctr_value!=target (edge-detected; one event per arrival of the count).
REQ-026 Target 0 disables matching.
REQ-027 On match: irq set, match_cnt increments (wraps at 2^MCNT_W-1 -> 0); one-shot -> HALT next cycle; periodic -> RELOAD next cycle.
REQ-028 Match and accepted STOP/CLEAR same cycle: command wins for the transition; match still sets irq and increments match_cnt, except CLEAR, which zeroes both.
REQ-029 irq_ack and match same cycle: irq stays set.
REQ-030 Edge-detect history is cleared on entry to RUN, so a count already equal to target at START produces a match in the first RUN cycle.
REQ-031 ctr_interval equals the interval register at all times.

Reset
REQ-032 resetn low asynchronously forces: FSM IDLE, ctr_state=8'd0, ctr_interval=0, target=0, mode one-shot, irq=0, match_cnt=0, cmd_err=0, cmd_ready=1, busy=0, edge history cleared.
REQ-033 Reset deassertion mid-operation restarts in IDLE; no pending command or match is retained.

Structure
REQ-034 Shared package timer_pkg holds state codes (RESET/RUN/HALT), opcode constants and mode constant.
REQ-035 One sub-module, timer_match, holds the target register, edge-detect flop and match pulse output.

Verification
REQ-036 SET_INTERVAL 3, SET_TARGET 5, SET_MODE 0, START; counter model advances -> single match at ctr_value 5, irq=1, match_cnt=1, ctr_state=8'd2 next cycle.
REQ-037 Periodic, target 2: three matches -> ctr_state shows exactly one cycle of 8'd0 after each match, match_cnt=3, busy high throughout.
REQ-038 SET_TARGET 9 while RUN -> cmd_err pulses one cycle, target remains 5; opcode 7 in IDLE -> cmd_err pulse.
REQ-039 irq_ack same cycle as match -> irq remains 1; irq_ack alone next cycle -> irq 0.
REQ-040 MCNT_W=4, 16 periodic matches -> match_cnt wraps to 0; CLEAR same cycle as a match -> match_cnt=0, irq=0, state IDLE.
REQ-041 resetn pulsed low between clock edges while RUN -> all outputs at reset values immediately; after release, START required to resume.
